// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes and datapath select values.
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StFetch   = 4'd0;
    localparam state_t StDecode  = 4'd1;
    localparam state_t StMemAddr = 4'd2;
    localparam state_t StMemRd   = 4'd3;
    localparam state_t StMemWb   = 4'd4;
    localparam state_t StMemWr   = 4'd5;
    localparam state_t StRExec   = 4'd6;
    localparam state_t StRWb     = 4'd7;
    localparam state_t StIExec   = 4'd8;
    localparam state_t StIWb     = 4'd9;
    localparam state_t StBranch  = 4'd10;
    localparam state_t StJump    = 4'd11;
    localparam state_t StErr     = 4'd12;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM with memory wait timeout and retired-instruction counter.
// Define MC_JUMP_EN to enable the JUMP state; otherwise opcode 000010 traps to ERR.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

    state_t             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // funct is decoded by the ALU control and zero is ANDed in the datapath.
    logic unused_inputs;
    assign unused_inputs = ^{funct, zero};

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        cnt_d         = cnt_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBReg;
        alu_op        = AluAdd;
        pc_source     = PcAlu;

        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = SrcBFour;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = SrcBImmSh;
                case (opcode)
                    OpRtype:    state_d = StRExec;
                    OpLw, OpSw: state_d = StMemAddr;
                    OpAddi:     state_d = StIExec;
                    OpBeq:      state_d = StBranch;
`ifdef MC_JUMP_EN
                    OpJ:        state_d = StJump;
`endif
                    default:    state_d = StErr;
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWr: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_op    = AluFunct;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = StIWb;
            end
            StIWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_source     = PcAluOut;
                state_d       = StFetch;
            end
`ifdef MC_JUMP_EN
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PcJump;
                state_d   = StFetch;
            end
`endif
            default: state_d = StErr;
        endcase

        // The WAIT_LIMIT-th consecutive stalled cycle traps instead of counting further.
        if (mem_req && !mem_ready) begin
            if (wait_q == WaitW'(WAIT_LIMIT - 1)) begin
                state_d = StErr;
            end else begin
                wait_d = wait_q + WaitW'(1);
            end
        end
        if (state_d != state_q) wait_d = '0;
        if (state_d == StFetch && state_q != StFetch) cnt_d = cnt_q + CNT_W'(1);

        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SrcBReg;
            alu_op        = AluAdd;
            pc_source     = PcAlu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign err         = (state_q == StErr);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle stimulus and expected state/control word queued, then drained.
module tb_mc_control_fsm;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'b100000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, err;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic [16:0] ctrl_w;

    // {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write, reg_dst,
    //  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, err}
    localparam logic [16:0] C_F_WAIT = 17'b1_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_F_RDY  = 17'b1_0_0_1_1_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MRD    = 17'b1_0_1_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWR    = 17'b1_1_1_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_REX    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RWB    = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
    localparam logic [16:0] C_IEX    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_IWB    = 17'b0_0_0_0_0_0_1_0_0_0_00_00_00_0;
    localparam logic [16:0] C_BR     = 17'b0_0_0_0_0_1_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JMP    = 17'b0_0_0_0_1_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_ERR    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
    localparam logic [16:0] C_OFF    = 17'b0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        zro;
        logic [3:0]  st;
        logic [16:0] ctrl;
    } ent_t;

    ent_t        sb[$];
    ent_t        e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 0;

    assign ctrl_w = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, err};

    mc_control_fsm #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .err(err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic push(input logic r, input logic rdy, input logic z, input logic [3:0] st,
                        input logic [16:0] c, input int reps);
        for (int i = 0; i < reps; i++) sb.push_back('{r, rdy, z, st, c});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ctrl_w !== C_OFF || state !== StFetch) begin
            n_fail++;
            $display("FAIL reset_hold: state=%0d ctrl=%b required state=%0d ctrl=%b",
                     state, ctrl_w, StFetch, C_OFF);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== StFetch || err !== 1'b0 || instr_count !== 32'd0 || ctrl_w !== C_F_WAIT) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d err=%b cnt=%0d ctrl=%b required %0d 0 0 %b",
                     state, err, instr_count, ctrl_w, StFetch, C_F_WAIT);
        end
    endtask

    task automatic test_rtype_addi();
        opcode = OpRtype;
        funct = 6'b100000;
        push(0, 1, 0, StFetch, C_F_RDY, 1);
        push(0, 1, 0, StDecode, C_DEC, 1);
        push(0, 1, 0, StRExec, C_REX, 1);
        push(0, 1, 0, StRWb, C_RWB, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; mem_ready = e.rdy; zero = e.zro;
            @(negedge clk);
            n_checks++;
            if (state !== e.st || ctrl_w !== e.ctrl) begin
                n_fail++;
                $display("FAIL rtype: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         state, ctrl_w, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_checks++;
        if (instr_count !== exp_cnt || state !== StFetch) begin
            n_fail++;
            $display("FAIL rtype_count: cnt=%0d state=%0d required %0d %0d",
                     instr_count, state, exp_cnt, StFetch);
        end
        opcode = OpAddi;
        push(0, 1, 0, StFetch, C_F_RDY, 1);
        push(0, 1, 0, StDecode, C_DEC, 1);
        push(0, 1, 0, StIExec, C_IEX, 1);
        push(0, 1, 0, StIWb, C_IWB, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; mem_ready = e.rdy; zero = e.zro;
            @(negedge clk);
            n_checks++;
            if (state !== e.st || ctrl_w !== e.ctrl) begin
                n_fail++;
                $display("FAIL addi: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         state, ctrl_w, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_checks++;
        if (instr_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL addi_count: cnt=%0d required %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_lw_sw();
        opcode = OpLw;
        push(0, 1, 0, StFetch, C_F_RDY, 1);
        push(0, 1, 0, StDecode, C_DEC, 1);
        push(0, 1, 0, StMemAddr, C_MADDR, 1);
        push(0, 0, 0, StMemRd, C_MRD, 3);
        push(0, 1, 0, StMemRd, C_MRD, 1);
        push(0, 1, 0, StMemWb, C_MWB, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; mem_ready = e.rdy; zero = e.zro;
            @(negedge clk);
            n_checks++;
            if (state !== e.st || ctrl_w !== e.ctrl) begin
                n_fail++;
                $display("FAIL lw_wait: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         state, ctrl_w, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        opcode = OpSw;
        push(0, 0, 0, StFetch, C_F_WAIT, 2);
        push(0, 1, 0, StFetch, C_F_RDY, 1);
        push(0, 1, 0, StDecode, C_DEC, 1);
        push(0, 1, 0, StMemAddr, C_MADDR, 1);
        push(0, 0, 0, StMemWr, C_MWR, 1);
        push(0, 1, 0, StMemWr, C_MWR, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; mem_ready = e.rdy; zero = e.zro;
            @(negedge clk);
            n_checks++;
            if (state !== e.st || ctrl_w !== e.ctrl) begin
                n_fail++;
                $display("FAIL sw: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         state, ctrl_w, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_checks++;
        if (instr_count !== exp_cnt || state !== StFetch) begin
            n_fail++;
            $display("FAIL lw_sw_count: cnt=%0d state=%0d required %0d %0d",
                     instr_count, state, exp_cnt, StFetch);
        end
    endtask

    task automatic test_beq();
        opcode = OpBeq;
        for (int z = 0; z < 2; z++) begin
            push(0, 1, 1'(z), StFetch, C_F_RDY, 1);
            push(0, 1, 1'(z), StDecode, C_DEC, 1);
            push(0, 1, 1'(z), StBranch, C_BR, 1);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                rst = e.rst; mem_ready = e.rdy; zero = e.zro;
                @(negedge clk);
                n_checks++;
                if (state !== e.st || ctrl_w !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL beq_z%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                             z, state, ctrl_w, e.st, e.ctrl);
                end
                @(posedge clk); #1;
            end
            exp_cnt++;
            n_checks++;
            if (instr_count !== exp_cnt || state !== StFetch) begin
                n_fail++;
                $display("FAIL beq_count: cnt=%0d state=%0d required %0d %0d",
                         instr_count, state, exp_cnt, StFetch);
            end
        end
    endtask

    // 14 stalls in FETCH and 14 in MEM_RD: legal only if the counter restarts per memory state.
    task automatic test_wait_boundary();
        opcode = OpLw;
        push(0, 0, 0, StFetch, C_F_WAIT, 14);
        push(0, 1, 0, StFetch, C_F_RDY, 1);
        push(0, 1, 0, StDecode, C_DEC, 1);
        push(0, 1, 0, StMemAddr, C_MADDR, 1);
        push(0, 0, 0, StMemRd, C_MRD, 14);
        push(0, 1, 0, StMemRd, C_MRD, 1);
        push(0, 1, 0, StMemWb, C_MWB, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; mem_ready = e.rdy; zero = e.zro;
            @(negedge clk);
            n_checks++;
            if (state !== e.st || ctrl_w !== e.ctrl) begin
                n_fail++;
                $display("FAIL wait_boundary: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         state, ctrl_w, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_checks++;
        if (instr_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL wait_boundary_count: cnt=%0d required %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_rst_mid();
        opcode = OpSw;
        push(0, 1, 0, StFetch, C_F_RDY, 1);
        push(0, 1, 0, StDecode, C_DEC, 1);
        push(0, 1, 0, StMemAddr, C_MADDR, 1);
        push(0, 0, 0, StMemWr, C_MWR, 2);
        push(1, 1, 0, StMemWr, C_OFF, 1);
        push(0, 0, 0, StFetch, C_F_WAIT, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; mem_ready = e.rdy; zero = e.zro;
            @(negedge clk);
            n_checks++;
            if (state !== e.st || ctrl_w !== e.ctrl) begin
                n_fail++;
                $display("FAIL rst_mid: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         state, ctrl_w, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_cnt = 0;
        n_checks++;
        if (instr_count !== exp_cnt || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_count: cnt=%0d err=%b required %0d 0", instr_count, err, exp_cnt);
        end
    endtask

    task automatic test_jump_illegal();
        opcode = OpJ;
        push(0, 1, 0, StFetch, C_F_RDY, 1);
        push(0, 1, 0, StDecode, C_DEC, 1);
`ifdef MC_JUMP_EN
        push(0, 1, 0, StJump, C_JMP, 1);
        exp_cnt++;
`else
        push(0, 1, 0, StErr, C_ERR, 1);
        push(1, 0, 0, StErr, C_ERR, 1);
        exp_cnt = 0;
`endif
        opcode = 6'b111111;
        push(0, 1, 0, StFetch, C_F_RDY, 1);
        push(0, 1, 0, StDecode, C_DEC, 1);
        push(0, 1, 0, StErr, C_ERR, 2);
        push(1, 1, 0, StErr, C_ERR, 1);
        // Opcode changes once the jump instruction has been fetched and decoded.
        opcode = OpJ;
        while (sb.size() != 0) begin
            if (sb.size() == 5) opcode = 6'b111111;
            e = sb.pop_front();
            rst = e.rst; mem_ready = e.rdy; zero = e.zro;
            @(negedge clk);
            n_checks++;
            if (state !== e.st || ctrl_w !== e.ctrl) begin
                n_fail++;
                $display("FAIL jump_illegal: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         state, ctrl_w, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_cnt = 0;
        n_checks++;
        if (instr_count !== exp_cnt || state !== StFetch || err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_recover: cnt=%0d state=%0d err=%b required %0d %0d 0",
                     instr_count, state, err, exp_cnt, StFetch);
        end
    endtask

    task automatic test_timeout();
        opcode = OpRtype;
        push(0, 0, 0, StFetch, C_F_WAIT, 15);
        push(0, 0, 0, StErr, C_ERR, 1);
        push(0, 1, 0, StErr, C_ERR, 2);
        push(1, 1, 0, StErr, C_ERR, 1);
        push(0, 0, 0, StFetch, C_F_WAIT, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; mem_ready = e.rdy; zero = e.zro;
            @(negedge clk);
            n_checks++;
            if (state !== e.st || ctrl_w !== e.ctrl) begin
                n_fail++;
                $display("FAIL timeout: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         state, ctrl_w, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (instr_count !== 32'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recover: cnt=%0d err=%b required 0 0", instr_count, err);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_addi();
        test_lw_sw();
        test_beq();
        test_wait_boundary();
        test_rst_mid();
        test_jump_illegal();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: maximum memory wait cycles per access before the block enters ERR.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completes the current mem_req access this cycle.
REQ-007 mem_req, mem_we, iord  out  1 each  memory strobe, write enable, and address select (0 = PC, 1 = ALUOut).
REQ-008 ir_write, pc_write, pc_write_cond, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath strobes and selects.
REQ-009 alu_src_b  out  2  (00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2); alu_op  out  2  (00 add, 01 sub, 10 use funct); pc_source  out  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-010 state  out  4  current state code; err  out  1  sticky error; instr_count  out  CNT_W  retired instructions.

Function
REQ-011 SHALL implement these states: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ERR.
REQ-012 Outputs SHALL be decoded combinationally from the registered state (Moore), except that the FETCH/MEM_RD/MEM_WR commit strobes are qualified by mem_ready.
REQ-013 FETCH: mem_req=1, iord=0, alu_src_b=01, alu_op=00; ir_write and pc_write assert only in the cycle mem_ready=1, which also moves the FSM to DECODE; otherwise hold FETCH.
REQ-014 DECODE: alu_src_b=11, no strobes; next state by opcode: 000000 R_EXEC, 100011/101011 MEM_ADDR, 001000 I_EXEC, 000100 BRANCH, 000010 JUMP; any other opcode goes to ERR.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, then MEM_RD for lw or MEM_WR for sw.
REQ-016 MEM_RD/MEM_WR: mem_req=1, iord=1, mem_we=1 (MEM_WR only); hold until mem_ready; then MEM_WB (lw) or FETCH (sw).
REQ-017 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. R_EXEC: alu_src_a=1, alu_op=10. R_WB: reg_write=1, reg_dst=1. I_EXEC: alu_src_a=1, alu_src_b=10. I_WB: reg_write=1, reg_dst=0. All of these advance unconditionally.
REQ-018 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01; PC is updated iff zero=1 (datapath ANDs); next state FETCH.
REQ-019 Latency with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each wait cycle adds 1.
REQ-020 Wait counter SHALL clear on entry to every memory state and increment on each cycle with mem_req=1 and mem_ready=0; when it reaches WAIT_LIMIT, next state is ERR.
REQ-021 ERR SHALL be absorbing: all strobes 0, err=1, until rst.
REQ-022 instr_count SHALL increment by 1 on the final cycle of each instruction (transition back to FETCH) and wrap modulo 2^CNT_W.

Reset
REQ-023 While rst=1, all strobes SHALL be 0. On the next edge: state=FETCH, err=0, instr_count=0, wait counter=0.
REQ-024 rst asserted mid-instruction (including during a memory wait) SHALL abort the instruction with no further register or PC write.

Configuration
REQ-025 With MC_JUMP_EN defined: JUMP state exists, pc_write=1, pc_source=10, next state FETCH.
REQ-026 With MC_JUMP_EN undefined: opcode 000010 SHALL go to ERR and pc_source never equals 10.

Structure
REQ-027 Package mc_pkg SHALL hold the state enum, opcode constants, and the alu_op/alu_src_b/pc_source encodings.
REQ-028 No sub-module; the wait counter and instr counter are inline.

Verification
REQ-029 R-type add (opcode 0, funct 100000), mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB; reg_write=1 and reg_dst=1 in cycle 4; instr_count 0->1.
REQ-030 lw with mem_ready low for 3 cycles in MEM_RD -> 8 total cycles; reg_write=1 exactly once with mem_to_reg=1.
REQ-031 beq with zero=0, then with zero=1 -> pc_write_cond=1 in cycle 3 both times; state returns to FETCH after 3 cycles.
REQ-032 mem_ready held 0 in FETCH with WAIT_LIMIT=15 -> ERR after 15 wait cycles; err=1, all strobes 0; rst clears to FETCH.
REQ-033 opcode 000010: MC_JUMP_EN defined -> pc_source=10, pc_write=1 in cycle 3; undefined -> ERR after DECODE.
REQ-034 rst pulsed in MEM_WR -> no further mem_we; state=FETCH, instr_count=0.
